// File: rtl/taillight_seq_if.sv
// Lamp-sequencer signal bundle: driver switch requests in, lamp drives out.
// Optional feature macro: TAILLIGHT_BRAKE_EN (adds the brake request B).
`timescale 1ns/1ps

interface taillight_seq_if #(
    parameter int LAMPS = 3
);
    logic             L;
    logic             R;
    logic             H;
`ifdef TAILLIGHT_BRAKE_EN
    logic             B;
`endif
    logic [LAMPS-1:0] lamp_l;
    logic [LAMPS-1:0] lamp_r;
    logic             busy;

`ifdef TAILLIGHT_BRAKE_EN
    modport master (output L, R, H, B, input lamp_l, lamp_r, busy);
    modport slave  (input L, R, H, B, output lamp_l, lamp_r, busy);
`else
    modport master (output L, R, H, input lamp_l, lamp_r, busy);
    modport slave  (input L, R, H, output lamp_l, lamp_r, busy);
`endif
endinterface

// File: rtl/taillight_seq.sv
// Parametrised tail-light sequencer: thermometer "fill" per side for turns,
// whole-side flash for hazard, stepped by a free-running prescaler.
// Optional feature macro: TAILLIGHT_BRAKE_EN (brake forces idle sides on).
`timescale 1ns/1ps

module taillight_seq #(
    parameter int LAMPS = 3,
    parameter int DIV   = 1
) (
    input logic          clk,
    input logic          reset,
    taillight_seq_if.slave bus
);
    localparam int PH_W  = $clog2(LAMPS + 1);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(LAMPS);
    localparam logic [PH_W-1:0]  FIRST_PH = PH_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    state_t           start_state;
    logic [PH_W-1:0]  phase;
    logic [PH_W-1:0]  phase_nx;
    logic [PH_W-1:0]  start_phase;
    logic [CNT_W-1:0] count;
    logic             tick;
    logic             haz;
    logic [LAMPS-1:0] fill;
    logic [LAMPS-1:0] lamp_l_nx;
    logic [LAMPS-1:0] lamp_r_nx;
    logic             busy_nx;
    logic [LAMPS-1:0] lamp_l_q;
    logic [LAMPS-1:0] lamp_r_q;
    logic             busy_q;

    assign tick = (count == LAST_CNT);
    assign haz  = bus.H | (bus.L & bus.R);

    // Free-running step prescaler; requests never restart it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Where a fresh sequence would begin from idle, with priority Haz > L > R.
    always_comb begin
        start_state = IDLE;
        start_phase = '0;
        if (haz) begin
            start_state = HAZ;
            start_phase = FIRST_PH;
        end else if (bus.L) begin
            start_state = LEFT;
            start_phase = FIRST_PH;
        end else if (bus.R) begin
            start_state = RIGHT;
            start_phase = FIRST_PH;
        end
    end

    // Next state and phase; everything holds between prescaler ticks.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        if (tick) begin
            case (state)
                IDLE: begin
                    state_nx = start_state;
                    phase_nx = start_phase;
                end
                LEFT, RIGHT: begin
                    if (haz) begin
                        state_nx = HAZ;
                        phase_nx = FIRST_PH;
                    end else if (phase == '0) begin
                        state_nx = start_state;
                        phase_nx = start_phase;
                    end else if (phase == LAST_PH) begin
                        phase_nx = '0;
                    end else begin
                        phase_nx = phase + 1'b1;
                    end
                end
                HAZ: begin
                    if (phase != '0) begin
                        phase_nx = '0;
                    end else if (haz) begin
                        phase_nx = FIRST_PH;
                    end else begin
                        state_nx = start_state;
                        phase_nx = start_phase;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    phase_nx = '0;
                end
            endcase
        end
    end

    // State and phase register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
        end
    end

    // Lamp patterns decoded from the upcoming state/phase so outputs are registered.
    always_comb begin
        fill      = '0;
        lamp_l_nx = '0;
        lamp_r_nx = '0;
        for (int k = 0; k < LAMPS; k++) begin
            fill[k] = (k < int'(phase_nx));
        end
        case (state_nx)
            LEFT:    lamp_l_nx = fill;
            RIGHT:   lamp_r_nx = fill;
            HAZ: begin
                if (phase_nx != '0) begin
                    lamp_l_nx = '1;
                    lamp_r_nx = '1;
                end
            end
            default: ;
        endcase
`ifdef TAILLIGHT_BRAKE_EN
        if (bus.B && (state_nx != HAZ)) begin
            if (state_nx != LEFT) begin
                lamp_l_nx = '1;
            end
            if (state_nx != RIGHT) begin
                lamp_r_nx = '1;
            end
        end
`endif
        busy_nx = (state_nx != IDLE);
    end

    // Output register, loaded on the same ticks that move the sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lamp_l_q <= '0;
            lamp_r_q <= '0;
            busy_q   <= 1'b0;
        end else if (tick) begin
            lamp_l_q <= lamp_l_nx;
            lamp_r_q <= lamp_r_nx;
            busy_q   <= busy_nx;
        end
    end

    assign bus.lamp_l = lamp_l_q;
    assign bus.lamp_r = lamp_r_q;
    assign bus.busy   = busy_q;

endmodule
